mem_arbiter: RTL and testbench

//  Shares one block-wide main memory between the I-cache (read-only) and the D-cache (read/write).

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the I-cache, D-cache and main-memory block buses that meet at the
// memory arbiter.
//   slave  : arbiter view. It takes the cache requests and the memory
//            response, and drives the cache responses and the memory command.
//   master : environment view. The caches and the memory model drive the
//            opposite directions.
// Signals (widths from ADDR_WIDTH / BLOCK_WIDTH):
//   I_READ, I_ADDR, I_READDATA, I_BUSYWAIT                     I-cache port
//   D_READ, D_WRITE, D_ADDR, D_WRITEDATA, D_READDATA, D_BUSYWAIT D-cache port
//   MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
//   MEM_READDATA, MEM_BUSYWAIT                                 memory port
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
);
  logic                   I_READ;
  logic [ADDR_WIDTH-1:0]  I_ADDR;
  logic [BLOCK_WIDTH-1:0] I_READDATA;
  logic                   I_BUSYWAIT;

  logic                   D_READ;
  logic                   D_WRITE;
  logic [ADDR_WIDTH-1:0]  D_ADDR;
  logic [BLOCK_WIDTH-1:0] D_WRITEDATA;
  logic [BLOCK_WIDTH-1:0] D_READDATA;
  logic                   D_BUSYWAIT;

  logic                   MEM_READ;
  logic                   MEM_WRITE;
  logic [ADDR_WIDTH-1:0]  MEM_ADDR;
  logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA;
  logic [BLOCK_WIDTH-1:0] MEM_READDATA;
  logic                   MEM_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one block-wide main memory between the read-only I-cache and the
// read/write D-cache. One requester is granted at a time. Its command is
// forwarded to memory, and the block is returned with a BUSYWAIT handshake.
// This gives each cache the same view it would have of a private memory.
// Ports:
//   CLK    clock; all state updates happen on the falling edge, to match the
//          cache FSMs
//   RESET  asynchronous, active-high reset
//   bus    mem_arbiter_if.slave (cache request/response ports, memory port)
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  when defined, contention alternates between the
//                           two sides. When undefined, the D-cache always
//                           wins contention.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    I_ACCESS = 3'd1,
    D_ACCESS = 3'd2,
    I_DONE   = 3'd3,
    D_DONE   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCK_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_WIDTH-1:0] d_rdata_q, d_rdata_d;
  // Set when the granted D-cache operation is a write-back.
  logic                   d_wr_q, d_wr_d;
  logic                   d_req_s;
  logic                   d_wins_s;

  // A D-cache request that asserts both READ and WRITE is treated as a write.
  assign d_req_s = bus.D_READ | bus.D_WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the D-cache.
  logic last_d_q, last_d_d;
  // On contention, the side that did not win last time now wins.
  assign d_wins_s = d_req_s & (~bus.I_READ | ~last_d_q);
`else
  // The D-cache wins any contention. A steady D stream can starve the I-cache.
  assign d_wins_s = d_req_s;
`endif

  assign bus.MEM_ADDR      = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.I_READDATA    = i_rdata_q;
  assign bus.D_READDATA    = d_rdata_q;

  // Next-state, grant and output decode. BUSYWAIT follows the request unless that side is granted.
  always_comb begin
    state_d        = state_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    d_wr_d         = d_wr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_d       = last_d_q;
`endif
    bus.MEM_READ   = 1'b0;
    bus.MEM_WRITE  = 1'b0;
    bus.I_BUSYWAIT = bus.I_READ;
    bus.D_BUSYWAIT = d_req_s;
    case (state_q)
      IDLE: begin
        if (d_wins_s) begin
          state_d     = D_ACCESS;
          mem_addr_d  = bus.D_ADDR;
          mem_wdata_d = bus.D_WRITEDATA;
          d_wr_d      = bus.D_WRITE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_d    = 1'b1;
`endif
        end else if (bus.I_READ) begin
          state_d     = I_ACCESS;
          mem_addr_d  = bus.I_ADDR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_d    = 1'b0;
`endif
        end else begin
          state_d     = IDLE;
        end
      end
      I_ACCESS: begin
        bus.MEM_READ   = 1'b1;
        bus.I_BUSYWAIT = 1'b1;
        // The transaction completes even if I_READ was dropped meanwhile.
        if (!bus.MEM_BUSYWAIT) begin
          i_rdata_d = bus.MEM_READDATA;
          state_d   = I_DONE;
        end else begin
          state_d   = I_ACCESS;
        end
      end
      D_ACCESS: begin
        bus.MEM_READ   = ~d_wr_q;
        bus.MEM_WRITE  = d_wr_q;
        bus.D_BUSYWAIT = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          if (!d_wr_q) begin
            d_rdata_d = bus.MEM_READDATA;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          state_d = D_DONE;
        end else begin
          state_d = D_ACCESS;
        end
      end
      I_DONE: begin
        bus.I_BUSYWAIT = 1'b0;
        state_d        = IDLE;
      end
      D_DONE: begin
        bus.D_BUSYWAIT = 1'b0;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. These update on the falling edge and clear asynchronously on RESET.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {BLOCK_WIDTH{1'b0}};
      i_rdata_q   <= {BLOCK_WIDTH{1'b0}};
      d_rdata_q   <= {BLOCK_WIDTH{1'b0}};
      d_wr_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_wr_q      <= d_wr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. It runs a table of single transactions,
// hand-written contention/reset/drop sequences, and randomized traffic that is
// compared against a transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();
  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [BW-1:0] init_blk(input int i);
    logic [31:0] a;
    a = 32'(i);
    return {32'hB000_0000 | a, 32'hB100_0000 | a, 32'hB200_0000 | a, 32'hB300_0000 | a};
  endfunction

  // Memory model: BUSYWAIT rises with the strobe and drops after mem_lat edges.
  logic [BW-1:0] mem_arr [64];
  int mem_lat = 1;
  int mem_cnt;
  logic strobe_s;
  assign strobe_s          = bus.MEM_READ | bus.MEM_WRITE;
  assign bus.MEM_BUSYWAIT  = strobe_s && (mem_cnt != mem_lat);
  assign bus.MEM_READDATA  = mem_arr[bus.MEM_ADDR[5:0]];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt <= 0;
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_blk(i);
    end else if (!strobe_s) begin
      mem_cnt <= 0;
    end else if (mem_cnt == mem_lat) begin
      mem_cnt <= 0;
      if (bus.MEM_WRITE) mem_arr[bus.MEM_ADDR[5:0]] <= bus.MEM_WRITEDATA;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model state (transaction level) ----------------
  logic [BW-1:0] ref_mem [64];
  int            m_own;      // 0 none, 1 I-cache, 2 D-cache
  int            m_rem;      // cycles left in the current grant; 1 = completion cycle
  logic          m_last_d;
  logic [AW-1:0] g_addr;
  logic          g_wr;
  logic [BW-1:0] g_wdata;
  logic          i_req, d_rd, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [BW-1:0] d_wdata;

  task automatic do_reset();
    bus.I_READ = 1'b0; bus.D_READ = 1'b0; bus.D_WRITE = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_blk(i);
    m_own = 0; m_rem = 0; m_last_d = 1'b0;
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            lat;
    int            exp_cycles;
    logic          exp_mrd;
    logic          exp_mwr;
    logic [BW-1:0] exp_rdata;
    logic          chk_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic done;
    @(posedge clk);
    mem_lat = v.lat;
    if (v.is_d) begin
      bus.D_READ = v.rd; bus.D_WRITE = v.wr; bus.D_ADDR = v.addr; bus.D_WRITEDATA = v.wdata;
    end else begin
      bus.I_READ = 1'b1; bus.I_ADDR = v.addr;
    end
    @(posedge clk);
    chk1($sformatf("v%0d MEM_READ", idx), bus.MEM_READ, v.exp_mrd);
    chk1($sformatf("v%0d MEM_WRITE", idx), bus.MEM_WRITE, v.exp_mwr);
    chkw($sformatf("v%0d MEM_ADDR", idx), BW'(bus.MEM_ADDR), BW'(v.addr));
    if (v.exp_mwr) chkw($sformatf("v%0d MEM_WRITEDATA", idx), bus.MEM_WRITEDATA, v.wdata);
    n = 1; done = 1'b0;
    while (!done && n < 20) begin
      if ((v.is_d ? bus.D_BUSYWAIT : bus.I_BUSYWAIT) == 1'b0) done = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chki($sformatf("v%0d latency", idx), n, v.exp_cycles);
    if (v.chk_rdata)
      chkw($sformatf("v%0d READDATA", idx), v.is_d ? bus.D_READDATA : bus.I_READDATA, v.exp_rdata);
    bus.I_READ = 1'b0; bus.D_READ = 1'b0; bus.D_WRITE = 1'b0;
    @(posedge clk);
    chk1($sformatf("v%0d idle strobe", idx), strobe_s, 1'b0);
  endtask

  // One randomized cycle: compare against the model, update the cache stimulus, then advance the model one edge.
  task automatic rnd_cycle(input bit allow_new);
    logic in_acc, exp_ibw, exp_dbw, pick_d, d_any;
    int   kind;
    @(posedge clk);
    in_acc  = (m_own != 0) && (m_rem > 1);
    exp_ibw = (m_own == 1) ? (m_rem != 1) : i_req;
    exp_dbw = (m_own == 2) ? (m_rem != 1) : (d_rd | d_wr);
    chk1("rnd I_BUSYWAIT", bus.I_BUSYWAIT, exp_ibw);
    chk1("rnd D_BUSYWAIT", bus.D_BUSYWAIT, exp_dbw);
    chk1("rnd MEM_READ", bus.MEM_READ, in_acc && !(m_own == 2 && g_wr));
    chk1("rnd MEM_WRITE", bus.MEM_WRITE, in_acc && m_own == 2 && g_wr);
    if (in_acc) chkw("rnd MEM_ADDR", BW'(bus.MEM_ADDR), BW'(g_addr));
    if (in_acc && m_own == 2 && g_wr) chkw("rnd MEM_WRITEDATA", bus.MEM_WRITEDATA, g_wdata);
    if (m_own == 1 && m_rem == 1) begin
      chkw("rnd I_READDATA", bus.I_READDATA, ref_mem[g_addr[5:0]]);
      i_req = 1'b0;
    end
    if (m_own == 2 && m_rem == 1) begin
      if (g_wr) ref_mem[g_addr[5:0]] = g_wdata;
      else chkw("rnd D_READDATA", bus.D_READDATA, ref_mem[g_addr[5:0]]);
      d_rd = 1'b0; d_wr = 1'b0;
    end
    if (allow_new && !i_req && m_own != 1 && $urandom_range(2) == 0) begin
      i_req = 1'b1; i_addr = AW'($urandom);
    end
    if (allow_new && !(d_rd | d_wr) && m_own != 2 && $urandom_range(2) == 0) begin
      kind    = int'($urandom_range(2));
      d_rd    = (kind != 1);
      d_wr    = (kind != 0);
      d_addr  = AW'($urandom);
      d_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.I_READ = i_req; bus.I_ADDR = i_addr;
    bus.D_READ = d_rd; bus.D_WRITE = d_wr; bus.D_ADDR = d_addr; bus.D_WRITEDATA = d_wdata;
    d_any = d_rd | d_wr;
    if (m_own != 0) begin
      m_rem--;
      if (m_rem == 0) m_own = 0;
    end else if (i_req || d_any) begin
      if (i_req && d_any) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = !m_last_d;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = d_any;
      end
      m_last_d = pick_d;
      m_rem    = mem_lat + 2;
      if (pick_d) begin
        m_own = 2; g_addr = d_addr; g_wr = d_wr; g_wdata = d_wdata;
      end else begin
        m_own = 1; g_addr = i_addr; g_wr = 1'b0;
      end
    end
  endtask

  vec_t vecs [8];
  int   got [4];
  int   exp_order [4];

  initial begin
    int k, cyc, cnt;
    int lat_tab [3];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0, 3, 5, 1'b1, 1'b0,
                128'hB0000010_B1000010_B2000010_B3000010, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 28'h0000020, {4{32'hA5A5A5A5}}, 2, 4, 1'b0, 1'b1, 128'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 28'h0000020, 128'h0, 0, 2, 1'b1, 1'b0, {4{32'hA5A5A5A5}}, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 28'h0000020, 128'h0, 1, 3, 1'b1, 1'b0, {4{32'hA5A5A5A5}}, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 28'h0000021, {4{32'h5A5A5A5A}}, 1, 3, 1'b0, 1'b1, 128'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 28'h0000021, 128'h0, 2, 4, 1'b1, 1'b0, {4{32'h5A5A5A5A}}, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 28'h000003F, 128'h0, 3, 5, 1'b1, 1'b0,
                128'hB000003F_B100003F_B200003F_B300003F, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 28'hABCDE05, 128'h0, 0, 2, 1'b1, 1'b0,
                128'hB0000005_B1000005_B2000005_B3000005, 1'b1};

    bus.I_READ = 1'b1; bus.I_ADDR = '0;
    bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_ADDR = '0; bus.D_WRITEDATA = '0;
    rst = 1'b1;
    #1;
    chk1("reset MEM_READ", bus.MEM_READ, 1'b0);
    chk1("reset MEM_WRITE", bus.MEM_WRITE, 1'b0);
    chkw("reset MEM_ADDR", BW'(bus.MEM_ADDR), '0);
    chkw("reset I_READDATA", bus.I_READDATA, '0);
    chkw("reset D_READDATA", bus.D_READDATA, '0);
    chk1("reset I_BUSYWAIT follows I_READ", bus.I_BUSYWAIT, 1'b1);
    chk1("reset D_BUSYWAIT", bus.D_BUSYWAIT, 1'b0);
    do_reset();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Contention with fixed arbitration state just after reset: D is served first.
    do_reset();
    mem_lat = 1;
    @(posedge clk);
    bus.I_READ = 1'b1; bus.I_ADDR = 28'h0000011;
    bus.D_READ = 1'b1; bus.D_ADDR = 28'h0000012;
    @(posedge clk);
    chk1("contend MEM_READ", bus.MEM_READ, 1'b1);
    chkw("contend MEM_ADDR D", BW'(bus.MEM_ADDR), BW'(28'h0000012));
    chk1("contend I_BUSYWAIT", bus.I_BUSYWAIT, 1'b1);
    @(posedge clk);
    @(posedge clk);
    chk1("contend D_BUSYWAIT done", bus.D_BUSYWAIT, 1'b0);
    chkw("contend D_READDATA", bus.D_READDATA, init_blk(32'h12));
    chk1("contend I still waiting", bus.I_BUSYWAIT, 1'b1);
    bus.D_READ = 1'b0;
    @(posedge clk);
    chk1("contend idle gap", bus.MEM_READ, 1'b0);
    @(posedge clk);
    chk1("contend I MEM_READ", bus.MEM_READ, 1'b1);
    chkw("contend MEM_ADDR I", BW'(bus.MEM_ADDR), BW'(28'h0000011));
    @(posedge clk);
    @(posedge clk);
    chk1("contend I_BUSYWAIT done", bus.I_BUSYWAIT, 1'b0);
    chkw("contend I_READDATA", bus.I_READDATA, init_blk(32'h11));
    bus.I_READ = 1'b0;

    // Four back-to-back contended grants: both sides hold their requests high throughout.
    do_reset();
    mem_lat = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{2, 1, 2, 1};
`else
    exp_order = '{2, 2, 2, 2};
`endif
    @(posedge clk);
    bus.I_READ = 1'b1; bus.I_ADDR = 28'h0000001;
    bus.D_READ = 1'b1; bus.D_ADDR = 28'h0000002;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      if (!bus.D_BUSYWAIT) begin got[k] = 2; k++; end
      if (k < 4 && !bus.I_BUSYWAIT) begin got[k] = 1; k++; end
    end
    chki("b2b grant count", k, 4);
    for (int j = 0; j < 4; j++) chki($sformatf("b2b grant %0d (2=D,1=I)", j), (j < k) ? got[j] : 0, exp_order[j]);
    bus.I_READ = 1'b0; bus.D_READ = 1'b0;
    repeat (10) @(posedge clk);

    // Asynchronous reset in the middle of a D write-back.
    mem_lat = 3;
    @(posedge clk);
    bus.D_WRITE = 1'b1; bus.D_ADDR = 28'h0000005; bus.D_WRITEDATA = {4{32'hDEADBEEF}};
    @(posedge clk);
    chk1("rstmid MEM_WRITE before", bus.MEM_WRITE, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("rstmid MEM_WRITE", bus.MEM_WRITE, 1'b0);
    chk1("rstmid MEM_READ", bus.MEM_READ, 1'b0);
    chkw("rstmid MEM_ADDR", BW'(bus.MEM_ADDR), '0);
    chkw("rstmid MEM_WRITEDATA", bus.MEM_WRITEDATA, '0);
    chkw("rstmid I_READDATA", bus.I_READDATA, '0);
    chkw("rstmid D_READDATA", bus.D_READDATA, '0);
    chk1("rstmid D_BUSYWAIT idle rule", bus.D_BUSYWAIT, 1'b1);
    bus.D_WRITE = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_blk(i);
    cnt = 0;
    repeat (3) begin
      @(posedge clk);
      if (strobe_s) cnt++;
    end
    chki("rstmid no retry strobes", cnt, 0);
    run_vec('{1'b0, 1'b1, 1'b0, 28'h0000005, 128'h0, 1, 3, 1'b1, 1'b0,
              128'hB0000005_B1000005_B2000005_B3000005, 1'b1}, 8);

    // I_READ dropped during the access: the transaction still completes, with one strobe only.
    mem_lat = 3;
    @(posedge clk);
    bus.I_READ = 1'b1; bus.I_ADDR = 28'h0000007;
    @(posedge clk);
    chk1("drop MEM_READ", bus.MEM_READ, 1'b1);
    bus.I_READ = 1'b0;
    cnt = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      if (bus.MEM_READ) cnt++;
      if (c == 3) chkw("drop I_READDATA latched", bus.I_READDATA, init_blk(32'h07));
    end
    chki("drop strobe cycles", cnt, 4);

    // Randomized traffic against the model.
    lat_tab = '{0, 1, 3};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      mem_lat = lat_tab[s];
      repeat (300) rnd_cycle(1'b1);
      repeat (40) rnd_cycle(1'b0);
      chk1("rnd drained", (m_own == 0) && !i_req && !(d_rd | d_wr), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
